// File: rtl/sub_acc_pkg.sv
// Shared types and helpers for the subtractor-result accumulator.
// The optional saturating build is selected with SUB_ACC_SATURATE_EN
// (see sub_acc_add).
package sub_acc_pkg;

    // Width of one subtractor result (offset-16 encoded).
    localparam int DIFF_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Offset-16 to signed: flipping the MSB turns (A-B)+16 into two's complement.
    function automatic logic signed [DIFF_W-1:0] decode_diff(input logic [DIFF_W-1:0] raw);
        return $signed({~raw[DIFF_W-1], raw[DIFF_W-2:0]});
    endfunction

endpackage

// File: rtl/sub_acc_add.sv
// Combinational ACC_W-bit signed adder with overflow flag.
// With SUB_ACC_SATURATE_EN defined an overflowing result clamps to the
// signed range limits; otherwise it wraps modulo 2^ACC_W.
module sub_acc_add #(
    parameter int ACC_W = 10
) (
    input  logic signed [ACC_W-1:0] a_i,
    input  logic signed [ACC_W-1:0] b_i,
    output logic signed [ACC_W-1:0] sum_o,
    output logic                    ovf_o
);

    localparam logic [ACC_W-1:0] MAX_POS = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] MAX_NEG = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0] raw;

    // Raw add; overflow when operands agree in sign but the result does not.
    always_comb begin
        raw   = a_i + b_i;
        ovf_o = (a_i[ACC_W-1] == b_i[ACC_W-1]) && (raw[ACC_W-1] != a_i[ACC_W-1]);
    end

`ifdef SUB_ACC_SATURATE_EN
    // Clamp toward the operands' common sign on overflow.
    always_comb begin
        sum_o = raw;
        if (ovf_o) sum_o = a_i[ACC_W-1] ? MAX_NEG : MAX_POS;
    end
`else
    // Wrapping build: the raw sum is the result.
    always_comb begin
        sum_o = raw;
    end
`endif

endmodule

// File: rtl/sub_result_accumulator.sv
// Accumulates N_SAMPLES signed subtractor differences and presents the sum
// once on an output handshake. Saturating vs. wrapping accumulation is
// chosen by SUB_ACC_SATURATE_EN (undefined: wrap).
module sub_result_accumulator
    import sub_acc_pkg::*;
#(
    parameter int N_SAMPLES = 8,
    parameter int ACC_W     = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DIFF_W-1:0]       diff_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] acc_out,
    output logic                    overflow,
    output logic                    busy
);

    localparam int               CNT_W = $clog2(N_SAMPLES + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_SAMPLES - 1);

    state_e                  state_q;
    logic signed [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    ovf_q;

    logic signed [DIFF_W-1:0] d_dec;
    logic signed [ACC_W-1:0]  d_ext;
    logic signed [ACC_W-1:0]  sum_d;
    logic                     add_ovf;
    logic                     accept;

    // Decode the incoming difference and sign-extend it to the accumulator width.
    always_comb begin
        d_dec  = decode_diff(diff_in);
        d_ext  = {{(ACC_W-DIFF_W){d_dec[DIFF_W-1]}}, d_dec};
        accept = in_valid && (state_q == ST_ACCUM);
    end

    sub_acc_add #(.ACC_W(ACC_W)) u_add (
        .a_i   (acc_q),
        .b_i   (d_ext),
        .sum_o (sum_d),
        .ovf_o (add_ovf)
    );

    // Run control FSM plus accumulator, sample counter and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_ACCUM;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        acc_q <= sum_d;
                        ovf_q <= ovf_q | add_ovf;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST) state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Handshake flags come straight from the state register.
    always_comb begin
        in_ready  = (state_q == ST_ACCUM);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q == ST_ACCUM) || (state_q == ST_DONE);
        acc_out   = acc_q;
        overflow  = ovf_q;
    end

endmodule

// File: tb/tb_sub_result_accumulator.sv
// Directed bench for sub_result_accumulator: three instances cover
// N=8/ACC_W=10, N=4/ACC_W=10 and N=3/ACC_W=6. Inputs driven and outputs
// sampled on the falling edge.
module tb_sub_result_accumulator;

`ifdef SUB_ACC_SATURATE_EN
    localparam int C_EXP = 31;
`else
    localparam int C_EXP = -19;
`endif

    logic clk, rst_n;

    logic a_start, a_iv, a_or, a_ir, a_ov, a_of, a_busy;
    logic [4:0] a_d;
    logic signed [9:0] a_acc;
    logic b_start, b_iv, b_or, b_ir, b_ov, b_of, b_busy;
    logic [4:0] b_d;
    logic signed [9:0] b_acc;
    logic c_start, c_iv, c_or, c_ir, c_ov, c_of, c_busy;
    logic [4:0] c_d;
    logic signed [5:0] c_acc;

    int checks = 0;
    int failures = 0;

    sub_result_accumulator #(.N_SAMPLES(8), .ACC_W(10)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .in_valid(a_iv), .in_ready(a_ir),
        .diff_in(a_d), .out_valid(a_ov), .out_ready(a_or), .acc_out(a_acc),
        .overflow(a_of), .busy(a_busy));
    sub_result_accumulator #(.N_SAMPLES(4), .ACC_W(10)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_iv), .in_ready(b_ir),
        .diff_in(b_d), .out_valid(b_ov), .out_ready(b_or), .acc_out(b_acc),
        .overflow(b_of), .busy(b_busy));
    sub_result_accumulator #(.N_SAMPLES(3), .ACC_W(6)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(c_start), .in_valid(c_iv), .in_ready(c_ir),
        .diff_in(c_d), .out_valid(c_ov), .out_ready(c_or), .acc_out(c_acc),
        .overflow(c_of), .busy(c_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        logic [4:0] bv [4];
        int cyc, acc_cnt;
        bv = '{5'd31, 5'd16, 5'd1, 5'd20};
        rst_n = 1'b0;
        {a_start, a_iv, a_or, b_start, b_iv, b_or, c_start, c_iv, c_or} = '0;
        a_d = '0; b_d = '0; c_d = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_a_acc", int'(a_acc), 0);
        chk("rst_a_flags", int'({a_ir, a_ov, a_of, a_busy}), 0);
        chk("rst_b_flags", int'({b_ir, b_ov, b_of, b_busy}), 0);
        chk("rst_c_acc", int'(c_acc), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_start_busy", int'(a_busy), 0);

        // Basic sum on N=4, with a start pulse while accumulating
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        chk("b_accum_ready", int'({b_busy, b_ir, b_ov}), 3'b110);
        for (int i = 0; i < 4; i++) begin
            b_iv = 1'b1;
            b_d  = bv[i];
            if (i == 2) b_start = 1'b1;
            @(negedge clk);
            b_start = 1'b0;
            if (i == 1) chk("b_acc_after2", int'(b_acc), 15);
            if (i == 2) chk("b_acc_after3_start_ignored", int'(b_acc), 0);
            if (i == 2) chk("b_ov_not_early", int'(b_ov), 0);
            if (i == 3) chk("b_ov_after_last", int'(b_ov), 1);
        end
        b_iv = 1'b0;
        chk("b_sum", int'(b_acc), 4);
        chk("b_ovf", int'(b_of), 0);
        chk("b_done_ready_low", int'(b_ir), 0);
        // Start in DONE ignored
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        chk("b_done_start_ignored_ov", int'(b_ov), 1);
        chk("b_done_start_ignored_acc", int'(b_acc), 4);
        // Transfer, then restart on the very next cycle
        b_or = 1'b1;
        @(negedge clk);
        b_or = 1'b0;
        chk("b_idle_after_xfer", int'({b_ov, b_busy}), 0);
        chk("b_acc_held_idle", int'(b_acc), 4);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        chk("b_restart_busy", int'(b_busy), 1);
        chk("b_restart_acc_clr", int'(b_acc), 0);

        // N=8, D=-15 each, in_valid toggling
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_d = 5'd1;
        cyc = 0;
        acc_cnt = 0;
        while (!a_ov && cyc < 40) begin
            a_iv = (cyc % 2 == 0);
            if (a_iv && a_ir) acc_cnt++;
            @(negedge clk);
            cyc++;
        end
        a_iv = 1'b0;
        chk("a_done_in_time", int'(cyc < 40), 1);
        chk("a_cycles", cyc, 15);
        chk("a_accepts", acc_cnt, 8);
        chk("a_sum", int'(a_acc), -120);
        chk("a_ovf", int'(a_of), 0);
        // Backpressure: out_ready low for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("a_bp_acc", int'(a_acc), -120);
            chk("a_bp_flags", int'({a_ov, a_ir}), 2'b10);
        end
        a_or = 1'b1;
        @(negedge clk);
        a_or = 1'b0;
        chk("a_xfer_done", int'(a_ov), 0);

        // Overflow: ACC_W=6, N=3, D=+15 x3
        c_start = 1'b1;
        @(negedge clk);
        c_start = 1'b0;
        c_iv = 1'b1;
        c_d  = 5'd31;
        repeat (2) @(negedge clk);
        chk("c_acc_30", int'(c_acc), 30);
        chk("c_no_ovf_yet", int'(c_of), 0);
        @(negedge clk);
        c_iv = 1'b0;
        chk("c_ov", int'(c_ov), 1);
        chk("c_acc_ovf", int'(c_acc), C_EXP);
        chk("c_ovf", int'(c_of), 1);
        c_or = 1'b1;
        @(negedge clk);
        c_or = 1'b0;
        chk("c_ovf_held_idle", int'(c_of), 1);
        c_start = 1'b1;
        @(negedge clk);
        c_start = 1'b0;
        chk("c_ovf_clr_on_start", int'(c_of), 0);

        // Mid-run asynchronous reset on N=8
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_iv = 1'b1;
        a_d  = 5'd17;
        repeat (3) @(negedge clk);
        chk("a_partial", int'(a_acc), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("a_rst_acc", int'(a_acc), 0);
        chk("a_rst_flags", int'({a_ir, a_ov, a_of, a_busy}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        a_iv = 1'b0;
        repeat (2) @(negedge clk);
        chk("a_after_rst_idle", int'({a_busy, a_ov}), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
